// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Shares one 4:1 multiplexed datapath between four valid/ready requesters.
//   A winner is chosen round-robin, and its word is latched into a single
//   registered output stage. That stage is then offered downstream with a
//   valid/ready handshake.
//
// Handshake semantics (both sides):
//   A word moves on a rising edge where valid and ready are both high.
//   - ready_o is combinational from valid_i, out_ready_i and state.
//     ready_o never depends on the data inputs.
//   - out_valid_o is purely registered (state == FULL).
//   - While out_valid_o is high and out_ready_i is low, out_o and sel_o are
//     held stable.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in1_i..in4_i requester 0..3 data words
//   valid_i[3:0] per-requester valid (bit k belongs to in(k+1)_i)
//   ready_o[3:0] per-requester accept strobe, one-hot or zero
//   out_o        registered output word
//   out_valid_o  output stage holds an unconsumed word (also the FSM state)
//   out_ready_i  downstream accepts out_o
//   sel_o        index of the requester whose word is in out_o
//
// Configuration:
//   MUX_ARB_FIXED_PRIO_EN defined -> fixed priority (requester 0 highest).
//     In this mode no rotation pointer is implemented.
//   undefined (default)          -> round-robin arbitration.
module mux4_rr_arbiter #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] in1_i,
  input  logic [Width-1:0] in2_i,
  input  logic [Width-1:0] in3_i,
  input  logic [Width-1:0] in4_i,
  input  logic [3:0]       valid_i,
  output logic [3:0]       ready_o,
  output logic [Width-1:0] out_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [1:0]       sel_o
);

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] out_q, out_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       grant;
  logic             any_valid;
  logic             accept;
  logic             xfer_in;
  logic             xfer_out;
  logic [Width-1:0] mux_data;

  assign any_valid = |valid_i;
  assign xfer_out  = (state_q == FULL) && out_ready_i;
  // The stage can take a word when it is empty or is being drained this cycle.
  assign accept    = (state_q == IDLE) || xfer_out;
  assign xfer_in   = accept && any_valid;

`ifdef MUX_ARB_FIXED_PRIO_EN
  // Lowest set bit wins. The loop scans downward so the last hit is the lowest.
  always_comb begin
    grant = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (valid_i[i]) grant = 2'(i);
    end
  end
`else
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx;
  logic       found;

  // Search starts at ptr_q and wraps modulo 4.
  // A requester that dropped valid is simply skipped.
  always_comb begin
    grant = ptr_q;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && valid_i[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  // The pointer only moves on a transfer in, so backpressure cannot skip anyone.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer_in) ptr_d = grant + 2'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= 2'd0;
    else         ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    mux_data = in1_i;
    case (grant)
      2'd0: mux_data = in1_i;
      2'd1: mux_data = in2_i;
      2'd2: mux_data = in3_i;
      2'd3: mux_data = in4_i;
      default: mux_data = in1_i;
    endcase
  end

  always_comb begin
    ready_o = 4'b0000;
    if (xfer_in) ready_o[grant] = 1'b1;
  end

  // Next-state and datapath load.
  // A transfer in takes precedence, which keeps FULL for back-to-back words.
  // A drain with no new word returns to IDLE, and out/sel hold their values.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    sel_d   = sel_q;
    if (xfer_in) begin
      state_d = FULL;
      out_d   = mux_data;
      sel_d   = grant;
    end else if (xfer_out) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      out_q   <= '0;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      sel_q   <= sel_d;
    end
  end

  assign out_o       = out_q;
  assign sel_o       = sel_q;
  assign out_valid_o = (state_q == FULL);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter
//   Directed bench for mux4_rr_arbiter.
//   Inputs are driven 1 time unit after each rising edge. Registered outputs
//   are checked at that point. Combinational ready_o is checked one unit
//   later, after the new inputs have settled.
//   The MUX_ARB_FIXED_PRIO_EN build runs the fixed-priority sequence.
//   The default build runs the round-robin sequence.
module tb_mux4_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] in1, in2, in3, in4;
  logic [3:0]  valid;
  logic [3:0]  ready;
  logic [31:0] out_w;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  sel;

  int checks = 0;
  int errors = 0;

  mux4_rr_arbiter #(.Width(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in1_i       (in1),
    .in2_i       (in2),
    .in3_i       (in3),
    .in4_i       (in4),
    .valid_i     (valid),
    .ready_o     (ready),
    .out_o       (out_w),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sel_o       (sel)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]  exp_sel [6];
    logic [31:0] exp_dat [6];
    exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_dat = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h11, 32'h22};

    rst_n = 1'b0; valid = 4'b0000; out_ready = 1'b0;
    in1 = 32'h0; in2 = 32'h0; in3 = 32'h0; in4 = 32'h0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", out_w, 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    rst_n = 1'b1;
    step();

`ifdef MUX_ARB_FIXED_PRIO_EN
    in1 = 32'h11; in2 = 32'h22; in3 = 32'h33; in4 = 32'h44;
    valid = 4'b1111; out_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("fp_ready", 32'(ready), 32'h1);
      step();
      check("fp_sel", 32'(sel), 32'd0);
      check("fp_out", out_w, 32'h11);
      check("fp_valid", 32'(out_valid), 32'd1);
    end
`else
    // Single request from requester 2.
    in3 = 32'hCAFE0003; valid = 4'b0100; out_ready = 1'b1;
    #1;
    check("single_ready", 32'(ready), 32'h4);
    step();
    check("single_out", out_w, 32'hCAFE0003);
    check("single_sel", 32'(sel), 32'd2);
    check("single_valid", 32'(out_valid), 32'd1);

    // Wrap and skip: ptr is 3 and only requesters 0 and 1 are valid.
    in1 = 32'hA0000001; in2 = 32'hA0000002; valid = 4'b0011;
    #1;
    check("wrap_ready0", 32'(ready), 32'h1);
    step();
    check("wrap_sel0", 32'(sel), 32'd0);
    check("wrap_out0", out_w, 32'hA0000001);
    #1;
    check("wrap_ready1", 32'(ready), 32'h2);
    step();
    check("wrap_sel1", 32'(sel), 32'd1);
    check("wrap_out1", out_w, 32'hA0000002);
    valid = 4'b0000;
    step();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_out_hold", out_w, 32'hA0000002);
    check("drain_sel_hold", 32'(sel), 32'd1);

    // Async reset while FULL.
    in4 = 32'hD0000004; valid = 4'b1000;
    step();
    check("pre_rst_sel", 32'(sel), 32'd3);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    valid = 4'b0000; out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_out", out_w, 32'd0);
    check("arst_sel", 32'(sel), 32'd0);
    #1;
    rst_n = 1'b1;
    valid = 4'b1000; out_ready = 1'b1;
    #1;
    check("post_rst_ready", 32'(ready), 32'h8);
    step();
    check("post_rst_sel", 32'(sel), 32'd3);
    check("post_rst_out", out_w, 32'hD0000004);

    // Full throughput rotation; ptr is 0 after the grant to 3.
    in1 = 32'h11; in2 = 32'h22; in3 = 32'h33; in4 = 32'h44;
    valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rot_sel", 32'(sel), 32'(exp_sel[i]));
      check("rot_out", out_w, exp_dat[i]);
      check("rot_valid", 32'(out_valid), 32'd1);
    end

    // Backpressure: last grant was 1, so ptr is 2.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ready", 32'(ready), 32'd0);
      step();
      check("bp_sel", 32'(sel), 32'd1);
      check("bp_out", out_w, 32'h22);
      check("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(ready), 32'h4);
    step();
    check("bp_release_sel", 32'(sel), 32'd2);
    check("bp_release_out", out_w, 32'h33);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one 4-to-1 multiplexed datapath between four valid/ready requesters. It selects a winner, latches that requester's word into a registered output stage, and presents it downstream with a valid/ready handshake. It sits directly in front of the shared consumer and drives the select of the 4:1 mux it controls.

## Interface
- Width, 32, data width of every input word and of out_o
- clk_i  input  1  clock; all state updates on rising edge
- rst_ni  input  1  asynchronous, active-low reset
- in1_i  input  Width  requester 0 data
- in2_i  input  Width  requester 1 data
- in3_i  input  Width  requester 2 data
- in4_i  input  Width  requester 3 data
- valid_i  input  4  per-requester valid; bit k belongs to in(k+1)_i
- ready_o  output  4  per-requester accept strobe, one-hot or zero
- out_o  output  Width  registered output word
- out_valid_o  output  1  out_o holds an unconsumed word
- out_ready_i  input  1  downstream accepts out_o
- sel_o  output  2  index of the requester whose word is in out_o

## Operation
- States: IDLE (output stage empty) and FULL (output stage holds a word).
- accept = (state == IDLE) || (out_valid_o && out_ready_i).
- Winner g is the first set bit of valid_i, searching from ptr upward and wrapping modulo 4 (ptr, ptr+1, …, ptr+3).
- ready_o[g] = accept && |valid_i. This is combinational from valid_i, out_ready_i and state. All other ready_o bits are 0.
- A transfer in from requester g happens on a cycle with valid_i[g] && ready_o[g]. At the clock edge: out_o <= mux(g), sel_o <= g, ptr <= (g+1) mod 4, state <= FULL.
- Transfer out happens on out_valid_o && out_ready_i. If no valid_i bit is set that cycle, state <= IDLE, and out_o and sel_o hold their values.
- Simultaneous transfer out and transfer in: stay FULL and load the new word. This gives full throughput of one word per cycle.
- FULL with out_ready_i=0: out_o, sel_o and ptr are frozen and ready_o = 0.
- ptr changes only on a transfer in. A requester that drops valid_i before it is granted loses nothing and is skipped.
- out_valid_o = (state == FULL).

## Timing
- Reset values: state = IDLE, ptr = 0, out_o = 0, sel_o = 0, out_valid_o = 0, ready_o = 0.
- Latency: a word accepted at edge N is visible on out_o with out_valid_o=1 after edge N. That is one cycle, input to output.
- Reset asserted mid-operation discards any held word immediately (asynchronously). Outputs go to reset values and ptr returns to 0.
- Fairness: with all four requesters continuously valid and out_ready_i=1, grants rotate 0,1,2,3,0,…. Any valid requester is granted within 4 accepts.

## Configuration
- MUX_ARB_FIXED_PRIO_EN defined: fixed priority, with requester 0 highest and requester 3 lowest. Winner = lowest set bit of valid_i. ptr is not implemented, and the other behaviour is unchanged.
- Not defined: round-robin as specified above.

## Test plan
- Reset, then single request: valid_i=4'b0100, in3_i=32'hCAFE0003, out_ready_i=1 -> ready_o=4'b0100 in that cycle. Next cycle out_o=32'hCAFE0003, sel_o=2, out_valid_o=1.
- All requesters valid continuously with distinct data 32'h11/22/33/44 and out_ready_i=1 -> sel_o sequence 0,1,2,3,0,1 on consecutive cycles, with no bubbles.
- Backpressure: FULL with out_ready_i=0 for 5 cycles while valid_i=4'b1111 -> ready_o=0, and out_o/sel_o stable. After out_ready_i=1, the next grant is the old ptr value.
- Wrap and skip: ptr=3 (after a grant to 2), valid_i=4'b0011 -> grant 0, then grant 1.
- Async reset: assert rst_ni low mid-cycle while FULL -> out_valid_o=0 and out_o=0 with no clock edge. After release with valid_i=4'b1000, the first grant is 3.
- With MUX_ARB_FIXED_PRIO_EN: valid_i=4'b1111 continuously with out_ready_i=1 -> sel_o=0 every cycle, and ready_o[3:1]=0.
